// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a 1-cycle-latency word-addressed RAM.
// Read bursts are issued under a credit limit so the return FIFO never
// overflows; write bursts are taken from a valid/ready stream and registered
// onto the RAM write port one cycle after each handshake.
module ram_burst_master #(
    parameter int DATA_SIZE  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic                                        cmd_write,
    input  logic [ADDR_WIDTH-$clog2(DATA_SIZE)-1:0]     cmd_addr,
    input  logic [LEN_WIDTH-1:0]                        cmd_len,
    input  logic                                        wdata_valid,
    output logic                                        wdata_ready,
    input  logic [8*DATA_SIZE-1:0]                      wdata,
    output logic                                        rdata_valid,
    input  logic                                        rdata_ready,
    output logic [8*DATA_SIZE-1:0]                      rdata,
    output logic                                        rdata_last,
    output logic                                        mem_rd_en,
    output logic [ADDR_WIDTH-$clog2(DATA_SIZE)-1:0]     mem_rd_addr,
    input  logic [8*DATA_SIZE-1:0]                      mem_rd_data,
    input  logic                                        mem_rd_valid,
    output logic                                        mem_wr_en,
    output logic [ADDR_WIDTH-$clog2(DATA_SIZE)-1:0]     mem_wr_addr,
    output logic [8*DATA_SIZE-1:0]                      mem_wr_data,
    output logic                                        busy,
    output logic                                        done
);

    localparam int DW = 8 * DATA_SIZE;
    localparam int AW = ADDR_WIDTH - $clog2(DATA_SIZE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = LEN_WIDTH + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RDRAIN,
        ST_WRITE,
        ST_WFLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_q, beat_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [DW-1:0]        wr_data_q, wr_data_d;
    logic [DW-1:0]        fifo_mem [FIFO_DEPTH];

    logic [CW:0]          credit_sum;
    logic                 issue;
    logic                 push;
    logic                 pop;

    // Read issue, FIFO return/drain handshakes and datapath outputs.
    always_comb begin
        credit_sum  = {1'b0, outst_q} + {1'b0, cnt_q};
        // Reads in flight plus entries held must leave room: the RAM cannot stall.
        issue       = (state_q == ST_READ) && (rem_q != '0) && (credit_sum < DEPTH_C);
        // A return with nothing outstanding is stale (e.g. issued before a reset).
        push        = mem_rd_valid && (outst_q != '0);
        rdata_valid = (cnt_q != '0);
        pop         = rdata_valid && rdata_ready;
        rdata       = rdata_valid ? fifo_mem[rptr_q] : '0;
        rdata_last  = rdata_valid && (beat_q == len_q);
        mem_rd_en   = issue;
        mem_rd_addr = issue ? addr_q : '0;
        mem_wr_en   = wr_en_q;
        mem_wr_addr = wr_addr_q;
        mem_wr_data = wr_data_q;
        busy        = (state_q != ST_IDLE);
    end

    // Outstanding-read and FIFO occupancy bookkeeping.
    always_comb begin
        outst_d = outst_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (issue && !push) begin
            outst_d = outst_q + CW'(1);
        end else if (!issue && push) begin
            outst_d = outst_q - CW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    // Burst FSM: next state, address/length counters and handshake outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        len_d       = len_q;
        beat_d      = pop ? beat_q + LEN_WIDTH'(1) : beat_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = {1'b0, cmd_len} + RW'(1);
                    len_d   = cmd_len;
                    beat_d  = '0;
                    state_d = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_d = ST_RDRAIN;
                    end
                end
            end
            ST_RDRAIN: begin
                if (pop && (beat_q == len_q)) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = wdata;
                    addr_d    = addr_q + AW'(1);
                    rem_d     = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_d = ST_WFLUSH;
                    end
                end
            end
            ST_WFLUSH: begin
                // The last registered write is on the RAM pins this cycle.
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            outst_q   <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            outst_q   <= outst_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Read-return FIFO storage; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed testbench for ram_burst_master with a 64-word, 1-cycle-latency RAM model.
module tb_ram_burst_master;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid, rdata_ready, rdata_last;
    logic [DW-1:0] rdata;
    logic          mem_rd_en, mem_rd_valid, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] mem_rd_data, mem_wr_data;
    logic          busy, done;

    // RAM model and its preload / injection controls
    logic [DW-1:0] ram [64];
    logic          ram_vld = 1'b0;
    logic [DW-1:0] ram_q   = '0;
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_a    = '0;
    logic [DW-1:0] pl_d    = '0;
    logic          inj_vld = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor logs
    logic [AW-1:0] rd_log[$];
    int            rd_cyc[$];
    logic [DW-1:0] bt_data[$];
    logic          bt_last[$];
    logic [AW-1:0] wr_alog[$];
    logic [DW-1:0] wr_dlog[$];
    int            wr_cyc[$];
    int            hs_cyc[$];
    int            done_cnt = 0;
    int            overlap_cnt = 0;

    int rb, bb, wb, hb, db;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        ram_vld <= mem_rd_en;
        if (mem_rd_en) ram_q <= ram[mem_rd_addr];
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (pl_en) ram[pl_a] <= pl_d;
    end

    assign mem_rd_valid = ram_vld | inj_vld;
    assign mem_rd_data  = inj_vld ? 32'hBADBAD00 : ram_q;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en && mem_wr_en) overlap_cnt++;
            if (mem_rd_en) begin
                rd_log.push_back(mem_rd_addr);
                rd_cyc.push_back(cyc);
            end
            if (rdata_valid && rdata_ready) begin
                bt_data.push_back(rdata);
                bt_last.push_back(rdata_last);
            end
            if (mem_wr_en) begin
                wr_alog.push_back(mem_wr_addr);
                wr_dlog.push_back(mem_wr_data);
                wr_cyc.push_back(cyc);
            end
            if (wdata_valid && wdata_ready) hs_cyc.push_back(cyc);
            if (done) done_cnt++;
        end
    end

    ram_burst_master #(
        .DATA_SIZE (4),
        .ADDR_WIDTH(8),
        .LEN_WIDTH (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_rd_valid(mem_rd_valid),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = 0;
        while (!cmd_ready && n < 30) begin
            step();
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input int gap);
        int n = 0;
        repeat (gap) step();
        wdata_valid = 1'b1;
        wdata       = d;
        while (!wdata_ready && n < 30) begin
            step();
            n++;
        end
        check("wdata_ready_wait", 64'(wdata_ready), 64'd1);
        step();
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc, input bit toggle);
        int d0 = done_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (toggle) rdata_ready = ~rdata_ready;
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic mark();
        rb = rd_log.size();
        bb = bt_data.size();
        wb = wr_alog.size();
        hb = hs_cyc.size();
        db = done_cnt;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_ctrl_outs", 64'({busy, done, mem_rd_en, mem_wr_en, rdata_valid, wdata_ready, rdata_last}), 64'd0);
        check("rst_data_outs", {rdata, mem_wr_data}, 64'd0);
        check("rst_addr_outs", 64'({mem_rd_addr, mem_wr_addr}), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) preload(AW'(6'h10 + i), 32'hA0 + i);
        for (int i = 0; i < 8; i++) preload(AW'(6'h20 + i), 32'hB0 + i);
        for (int i = 0; i < 4; i++) preload(AW'(6'h30 + i), 32'hC0 + i);
        preload(6'h07, 32'h77);

        // T1: read burst 0x10 len 3, consumer always ready
        rdata_ready = 1'b1;
        mark();
        send_cmd(1'b0, 6'h10, 8'd3);
        wait_done("t1_done_seen", 40, 1'b0);
        repeat (3) step();
        check("t1_nreads", 64'(rd_log.size() - rb), 64'd4);
        for (int i = 0; i < 4; i++) check("t1_rd_addr", 64'(rd_log[rb + i]), 64'(6'h10 + i));
        check("t1_consecutive", 64'(rd_cyc[rb + 3] - rd_cyc[rb]), 64'd3);
        check("t1_nbeats", 64'(bt_data.size() - bb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_rdata", 64'(bt_data[bb + i]), 64'(32'hA0 + i));
            check("t1_last", 64'(bt_last[bb + i]), 64'(i == 3));
        end
        check("t1_done_pulses", 64'(done_cnt - db), 64'd1);
        check("t1_cmd_ready", 64'(cmd_ready), 64'd1);

        // T2: read burst len 7 with consumer stalled for 10 cycles
        rdata_ready = 1'b0;
        mark();
        send_cmd(1'b0, 6'h20, 8'd7);
        repeat (10) step();
        check("t2_credit_stall", 64'(rd_log.size() - rb), 64'd4);
        check("t2_head_valid", 64'(rdata_valid), 64'd1);
        check("t2_head_data", 64'(rdata), 64'h0B0);
        step();
        check("t2_head_stable", 64'(rdata), 64'h0B0);
        check("t2_head_notlast", 64'(rdata_last), 64'd0);
        rdata_ready = 1'b1;
        wait_done("t2_done_seen", 60, 1'b0);
        repeat (3) step();
        check("t2_nreads", 64'(rd_log.size() - rb), 64'd8);
        check("t2_nbeats", 64'(bt_data.size() - bb), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2_rdata", 64'(bt_data[bb + i]), 64'(32'hB0 + i));
            check("t2_last", 64'(bt_last[bb + i]), 64'(i == 7));
        end
        check("t2_done_pulses", 64'(done_cnt - db), 64'd1);

        // T3: wrapping write burst 0x3E len 3 with gaps, then readback
        mark();
        send_cmd(1'b1, 6'h3E, 8'd3);
        send_beat(32'h11, 1);
        send_beat(32'h22, 0);
        send_beat(32'h33, 2);
        send_beat(32'h44, 1);
        wait_done("t3_done_seen", 20, 1'b0);
        repeat (2) step();
        check("t3_nwrites", 64'(wr_alog.size() - wb), 64'd4);
        check("t3_wr_addr0", 64'(wr_alog[wb + 0]), 64'h3E);
        check("t3_wr_addr1", 64'(wr_alog[wb + 1]), 64'h3F);
        check("t3_wr_addr2", 64'(wr_alog[wb + 2]), 64'h00);
        check("t3_wr_addr3", 64'(wr_alog[wb + 3]), 64'h01);
        for (int i = 0; i < 4; i++) begin
            check("t3_wr_data", 64'(wr_dlog[wb + i]), 64'(32'h11 * (i + 1)));
            check("t3_wr_latency", 64'(wr_cyc[wb + i] - hs_cyc[hb + i]), 64'd1);
        end
        check("t3_ram_3f", 64'(ram[6'h3F]), 64'h22);
        check("t3_ram_00", 64'(ram[6'h00]), 64'h33);
        check("t3_done_pulses", 64'(done_cnt - db), 64'd1);
        mark();
        send_cmd(1'b0, 6'h3E, 8'd3);
        wait_done("t3_rb_done_seen", 40, 1'b0);
        repeat (2) step();
        check("t3_rb_nbeats", 64'(bt_data.size() - bb), 64'd4);
        for (int i = 0; i < 4; i++) check("t3_rb_data", 64'(bt_data[bb + i]), 64'(32'h11 * (i + 1)));

        // T4: back-to-back write then read of 0x05
        mark();
        send_cmd(1'b1, 6'h05, 8'd0);
        send_beat(32'hDEADBEEF, 0);
        wait_done("t4_wr_done_seen", 20, 1'b0);
        send_cmd(1'b0, 6'h05, 8'd0);
        wait_done("t4_rd_done_seen", 20, 1'b0);
        repeat (2) step();
        check("t4_nbeats", 64'(bt_data.size() - bb), 64'd1);
        check("t4_rdata", 64'(bt_data[bb]), 64'hDEADBEEF);
        check("t4_last", 64'(bt_last[bb]), 64'd1);

        // T5: reset mid-read with one read outstanding
        rdata_ready = 1'b0;
        send_cmd(1'b0, 6'h30, 8'd3);
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t5_rst_ctrl", 64'({busy, done, mem_rd_en, mem_wr_en, rdata_valid, rdata_last}), 64'd0);
        check("t5_rst_rdata", 64'(rdata), 64'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("t5_stale_ignored", 64'(rdata_valid), 64'd0);
        inj_vld = 1'b1;
        step();
        inj_vld = 1'b0;
        step();
        check("t5_inject_ignored", 64'({busy, rdata_valid}), 64'd0);
        rdata_ready = 1'b1;
        mark();
        send_cmd(1'b0, 6'h30, 8'd0);
        wait_done("t5_done_seen", 20, 1'b0);
        repeat (3) step();
        check("t5_nbeats", 64'(bt_data.size() - bb), 64'd1);
        check("t5_rdata", 64'(bt_data[bb]), 64'h0C0);
        check("t5_last", 64'(bt_last[bb]), 64'd1);

        // T6: single-beat read with rdata_ready toggling
        rdata_ready = 1'b0;
        mark();
        send_cmd(1'b0, 6'h07, 8'd0);
        wait_done("t6_done_seen", 40, 1'b1);
        rdata_ready = 1'b1;
        repeat (5) step();
        check("t6_nreads", 64'(rd_log.size() - rb), 64'd1);
        check("t6_nbeats", 64'(bt_data.size() - bb), 64'd1);
        check("t6_rdata", 64'(bt_data[bb]), 64'h77);
        check("t6_last", 64'(bt_last[bb]), 64'd1);
        check("t6_done_pulses", 64'(done_cnt - db), 64'd1);

        check("no_rd_wr_overlap", 64'(overlap_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
